// File: rtl/if_stage_prefetch_queue.sv
`default_nettype none
// if_stage_prefetch_queue: pipelined fetch stage with an in-flight PC FIFO and an instruction queue.
// Redirects flush the queue and drop stale responses. Rev 1.0
module if_stage_prefetch_queue #(
  parameter logic [31:0] RESET_PC        = 32'h1C00_0000,
  parameter int          MAX_OUTSTANDING = 4,
  parameter int          IQ_DEPTH        = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_redirect,
  input  logic [31:0] wb_target,
  input  logic        br_redirect,
  input  logic [31:0] br_target,
  input  logic        ds_allowin,
  output logic        fs_to_ds_valid,
  output logic [64:0] fs_to_ds_bus,
  output logic        inst_sram_req,
  output logic        inst_sram_wr,
  output logic [1:0]  inst_sram_size,
  output logic [3:0]  inst_sram_wstrb,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata
);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int FW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int IW = $clog2(IQ_DEPTH);
  localparam int QW = $clog2(IQ_DEPTH + 1);

  logic [31:0]   fetch_pc;
  logic [CW-1:0] out_cnt;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] live_cnt;
  logic [31:0]   pc_fifo [MAX_OUTSTANDING];
  logic [FW-1:0] pf_wr;
  logic [FW-1:0] pf_rd;
  logic [64:0]   iq_mem [IQ_DEPTH];
  logic [IW-1:0] iq_wr;
  logic [IW-1:0] iq_rd;
  logic [QW-1:0] iq_cnt;
  logic          adef_halt;

  logic          redirect;
  logic [31:0]   redirect_pc;
  logic          aligned;
  logic          credit_ok;
  logic          handshake;
  logic          drop_resp;
  logic          resp_write;
  logic          adef_write;
  logic          iq_write;
  logic          iq_pop;
  logic          iq_full;
  logic [64:0]   iq_wdata;

  function automatic logic [FW-1:0] pf_inc(input logic [FW-1:0] p);
    return (p == FW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [IW-1:0] iq_inc(input logic [IW-1:0] p);
    return (p == IW'(IQ_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign redirect    = wb_redirect | br_redirect;
  assign redirect_pc = wb_redirect ? wb_target : br_target;
  assign aligned     = (fetch_pc[1:0] == 2'b00);
  assign live_cnt    = out_cnt - drop_cnt;
  assign iq_full     = (iq_cnt == QW'(IQ_DEPTH));

  // Reserve an IQ slot for every live request so responses can never overflow the queue.
  assign credit_ok = (out_cnt < CW'(MAX_OUTSTANDING)) &&
                     ((32'(live_cnt) + 32'(iq_cnt)) < 32'(IQ_DEPTH));

  assign inst_sram_req   = ~reset & ~redirect & ~adef_halt & aligned & credit_ok;
  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = 2'b10;
  assign inst_sram_wstrb = 4'h0;
  assign inst_sram_addr  = fetch_pc;
  assign inst_sram_wdata = 32'h0;

  assign handshake  = inst_sram_req & inst_sram_addr_ok;
  assign drop_resp  = (drop_cnt != '0);
  assign resp_write = inst_sram_data_ok & ~redirect & ~drop_resp;
  // Only once every live response has landed, so the fault entry stays in program order.
  assign adef_write = ~aligned & ~redirect & ~adef_halt & (out_cnt == drop_cnt) & ~iq_full;
  assign iq_write   = resp_write | adef_write;
  assign iq_wdata   = adef_write ? {1'b1, 32'h0, fetch_pc}
                                 : {1'b0, inst_sram_rdata, pc_fifo[pf_rd]};

  assign fs_to_ds_valid = (iq_cnt != '0);
  assign fs_to_ds_bus   = fs_to_ds_valid ? iq_mem[iq_rd] : 65'h0;
  assign iq_pop         = fs_to_ds_valid & ds_allowin & ~redirect;

  always_ff @(posedge clk) begin
    if (handshake) pc_fifo[pf_wr] <= fetch_pc;
    if (iq_write)  iq_mem[iq_wr]  <= iq_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc  <= RESET_PC;
      out_cnt   <= '0;
      drop_cnt  <= '0;
      pf_wr     <= '0;
      pf_rd     <= '0;
      iq_wr     <= '0;
      iq_rd     <= '0;
      iq_cnt    <= '0;
      adef_halt <= 1'b0;
    end else begin
      out_cnt <= out_cnt + CW'(handshake) - CW'(inst_sram_data_ok);
      if (handshake)         pf_wr <= pf_inc(pf_wr);
      if (inst_sram_data_ok) pf_rd <= pf_inc(pf_rd);
      if (redirect) begin
        fetch_pc  <= redirect_pc;
        drop_cnt  <= out_cnt - CW'(inst_sram_data_ok);
        adef_halt <= 1'b0;
        iq_wr     <= '0;
        iq_rd     <= '0;
        iq_cnt    <= '0;
      end else begin
        if (handshake)                     fetch_pc  <= fetch_pc + 32'd4;
        if (inst_sram_data_ok & drop_resp) drop_cnt  <= drop_cnt - CW'(1);
        if (adef_write)                    adef_halt <= 1'b1;
        if (iq_write)                      iq_wr     <= iq_inc(iq_wr);
        if (iq_pop)                        iq_rd     <= iq_inc(iq_rd);
        iq_cnt <= iq_cnt + QW'(iq_write) - QW'(iq_pop);
      end
    end
  end

  a_iq_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(iq_write && iq_full && !iq_pop));
  a_out_cnt_bound: assert property (@(posedge clk) disable iff (reset)
    (out_cnt <= CW'(MAX_OUTSTANDING)) && (drop_cnt <= out_cnt));

endmodule
`default_nettype wire

// File: tb/tb_if_stage_prefetch_queue.sv
`default_nettype none
// tb_if_stage_prefetch_queue: directed scenarios against a latency-programmable fetch slave.
// Rev 1.0
module tb_if_stage_prefetch_queue;
  localparam logic [31:0] RESET_PC = 32'h1C00_0000;
  localparam int          IQ_DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_redirect;
  logic [31:0] wb_target;
  logic        br_redirect;
  logic [31:0] br_target;
  logic        ds_allowin;
  logic        fs_to_ds_valid;
  logic [64:0] fs_to_ds_bus;
  logic        inst_sram_req;
  logic        inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int lat    = 2;
  int peak   = 0;

  logic [31:0] resp_addr [$];
  int          resp_due  [$];
  logic [64:0] got       [$];
  logic [31:0] hs_log    [$];

  always #5 clk = ~clk;

  if_stage_prefetch_queue #(
    .RESET_PC       (RESET_PC),
    .MAX_OUTSTANDING(4),
    .IQ_DEPTH       (IQ_DEPTH)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .wb_redirect      (wb_redirect),
    .wb_target        (wb_target),
    .br_redirect      (br_redirect),
    .br_target        (br_target),
    .ds_allowin       (ds_allowin),
    .fs_to_ds_valid   (fs_to_ds_valid),
    .fs_to_ds_bus     (fs_to_ds_bus),
    .inst_sram_req    (inst_sram_req),
    .inst_sram_wr     (inst_sram_wr),
    .inst_sram_size   (inst_sram_size),
    .inst_sram_wstrb  (inst_sram_wstrb),
    .inst_sram_addr   (inst_sram_addr),
    .inst_sram_wdata  (inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok),
    .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata  (inst_sram_rdata)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  function automatic logic [64:0] exp_entry(input logic [31:0] pc);
    return {1'b0, mem_word(pc), pc};
  endfunction

  // One clock: drive slave response, log handshake/consumption, advance to the next negedge.
  task automatic tick();
    logic        hs;
    logic [31:0] a;
    if (!reset && resp_due.size() > 0 && resp_due[0] == cyc) begin
      inst_sram_data_ok = 1'b1;
      inst_sram_rdata   = mem_word(resp_addr[0]);
    end else begin
      inst_sram_data_ok = 1'b0;
      inst_sram_rdata   = 32'h0;
    end
    #1;
    hs = inst_sram_req & inst_sram_addr_ok;
    a  = inst_sram_addr;
    if (fs_to_ds_valid && ds_allowin && !wb_redirect && !br_redirect && !reset)
      got.push_back(fs_to_ds_bus);
    @(posedge clk);
    if (reset) begin
      resp_addr.delete();
      resp_due.delete();
    end else begin
      if (inst_sram_data_ok && resp_addr.size() > 0) begin
        void'(resp_addr.pop_front());
        void'(resp_due.pop_front());
      end
      if (hs) begin
        resp_addr.push_back(a);
        resp_due.push_back(cyc + lat);
        hs_log.push_back(a);
      end
    end
    if (resp_addr.size() > peak) peak = resp_addr.size();
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    wb_redirect = 1'b0;
    br_redirect = 1'b0;
    ds_allowin = 1'b1;
    inst_sram_addr_ok = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    got.delete();
    hs_log.delete();
    peak = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++; if (fs_to_ds_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", fs_to_ds_valid); end
    checks++; if (inst_sram_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", inst_sram_req); end
    checks++; if (fs_to_ds_bus !== 65'h0) begin errors++; $display("FAIL reset_bus got %h want 0", fs_to_ds_bus); end
    checks++;
    if ({inst_sram_wr, inst_sram_size, inst_sram_wstrb, inst_sram_wdata} !== {1'b0, 2'b10, 4'h0, 32'h0}) begin
      errors++; $display("FAIL const_outputs got wr=%b size=%b wstrb=%h wdata=%h want 0/10/0/0",
                         inst_sram_wr, inst_sram_size, inst_sram_wstrb, inst_sram_wdata);
    end
  endtask

  task automatic test_sequential();
    int bubbles = 0;
    int first_valid = -1;
    lat = 2;
    inst_sram_addr_ok = 1'b1;
    ds_allowin = 1'b1;
    reset = 1'b0;
    #1;
    checks++; if (inst_sram_req !== 1'b1 || inst_sram_addr !== RESET_PC) begin
      errors++; $display("FAIL first_req got req=%b addr=%h want 1 %h", inst_sram_req, inst_sram_addr, RESET_PC);
    end
    for (int t = 1; t <= 14; t++) begin
      tick();
      if (first_valid >= 0 && !fs_to_ds_valid) bubbles++;
      if (first_valid < 0 && fs_to_ds_valid) first_valid = t;
    end
    checks++; if (first_valid != 3) begin errors++; $display("FAIL first_valid_tick got %0d want 3", first_valid); end
    checks++; if (peak != 2) begin errors++; $display("FAIL peak_outstanding got %0d want 2", peak); end
    checks++; if (bubbles != 0) begin errors++; $display("FAIL bubbles got %0d want 0", bubbles); end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (got.size() <= i || got[i] !== exp_entry(RESET_PC + 32'(4 * i))) begin
        errors++; $display("FAIL seq_entry%0d got %h want %h", i, (got.size() > i) ? got[i] : 65'h0,
                           exp_entry(RESET_PC + 32'(4 * i)));
      end
    end
  endtask

  task automatic test_backpressure();
    int n0;
    ds_allowin = 1'b0;
    for (int t = 0; t < 12; t++) tick();
    checks++; if (inst_sram_req !== 1'b0) begin errors++; $display("FAIL hold_req got %b want 0", inst_sram_req); end
    checks++; if (resp_addr.size() != 0) begin errors++; $display("FAIL hold_inflight got %0d want 0", resp_addr.size()); end
    checks++; if (hs_log.size() - got.size() != IQ_DEPTH) begin
      errors++; $display("FAIL hold_count got %0d want %0d", hs_log.size() - got.size(), IQ_DEPTH);
    end
    checks++; if (fs_to_ds_bus !== exp_entry(RESET_PC + 32'(4 * got.size()))) begin
      errors++; $display("FAIL hold_head got %h want %h", fs_to_ds_bus, exp_entry(RESET_PC + 32'(4 * got.size())));
    end
    n0 = got.size();
    ds_allowin = 1'b1;
    for (int t = 0; t < 10; t++) tick();
    for (int i = n0; i < n0 + 8; i++) begin
      checks++;
      if (got.size() <= i || got[i] !== exp_entry(RESET_PC + 32'(4 * i))) begin
        errors++; $display("FAIL resume_entry%0d got %h want %h", i, (got.size() > i) ? got[i] : 65'h0,
                           exp_entry(RESET_PC + 32'(4 * i)));
      end
    end
  endtask

  task automatic test_branch_flush();
    do_reset();
    lat = 3;
    tick();
    tick();
    tick();
    checks++; if (resp_addr.size() != 3) begin errors++; $display("FAIL flush_inflight got %0d want 3", resp_addr.size()); end
    br_redirect = 1'b1;
    br_target = 32'h1C00_0100;
    tick();
    br_redirect = 1'b0;
    got.delete();
    #1;
    checks++; if (fs_to_ds_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b want 0", fs_to_ds_valid); end
    checks++; if (inst_sram_req !== 1'b1 || inst_sram_addr !== 32'h1C00_0100) begin
      errors++; $display("FAIL flush_req got req=%b addr=%h want 1 1c000100", inst_sram_req, inst_sram_addr);
    end
    for (int t = 0; t < 10; t++) tick();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (got.size() <= i || got[i] !== exp_entry(32'h1C00_0100 + 32'(4 * i))) begin
        errors++; $display("FAIL flush_entry%0d got %h want %h", i, (got.size() > i) ? got[i] : 65'h0,
                           exp_entry(32'h1C00_0100 + 32'(4 * i)));
      end
    end
  endtask

  task automatic test_dual_redirect();
    do_reset();
    lat = 2;
    tick();
    tick();
    wb_redirect = 1'b1;
    wb_target = 32'h1C00_8000;
    br_redirect = 1'b1;
    br_target = 32'h1C00_0400;
    tick();
    wb_redirect = 1'b0;
    br_redirect = 1'b0;
    checks++; if (resp_addr.size() != 1) begin errors++; $display("FAIL dual_dataok_consumed got %0d want 1", resp_addr.size()); end
    got.delete();
    hs_log.delete();
    for (int t = 0; t < 8; t++) tick();
    checks++; if (hs_log.size() == 0 || hs_log[0] !== 32'h1C00_8000) begin
      errors++; $display("FAIL dual_fetch_addr got %h want 1c008000", (hs_log.size() > 0) ? hs_log[0] : 32'h0);
    end
    checks++; if (got.size() == 0 || got[0] !== exp_entry(32'h1C00_8000)) begin
      errors++; $display("FAIL dual_entry got %h want %h", (got.size() > 0) ? got[0] : 65'h0, exp_entry(32'h1C00_8000));
    end
  endtask

  task automatic test_adef();
    do_reset();
    lat = 2;
    for (int t = 0; t < 6; t++) tick();
    br_redirect = 1'b1;
    br_target = 32'h1C00_0102;
    tick();
    br_redirect = 1'b0;
    got.delete();
    hs_log.delete();
    for (int t = 0; t < 8; t++) tick();
    checks++; if (got.size() != 1) begin errors++; $display("FAIL adef_count got %0d want 1", got.size()); end
    checks++; if (got.size() == 0 || got[0] !== {1'b1, 32'h0, 32'h1C00_0102}) begin
      errors++; $display("FAIL adef_entry got %h want %h", (got.size() > 0) ? got[0] : 65'h0, {1'b1, 32'h0, 32'h1C00_0102});
    end
    checks++; if (hs_log.size() != 0 || inst_sram_req !== 1'b0) begin
      errors++; $display("FAIL adef_halt got hs=%0d req=%b want 0 0", hs_log.size(), inst_sram_req);
    end
    br_redirect = 1'b1;
    br_target = 32'h1C00_0200;
    tick();
    br_redirect = 1'b0;
    got.delete();
    hs_log.delete();
    for (int t = 0; t < 8; t++) tick();
    checks++; if (hs_log.size() == 0 || hs_log[0] !== 32'h1C00_0200) begin
      errors++; $display("FAIL adef_resume_addr got %h want 1c000200", (hs_log.size() > 0) ? hs_log[0] : 32'h0);
    end
    checks++; if (got.size() == 0 || got[0] !== exp_entry(32'h1C00_0200)) begin
      errors++; $display("FAIL adef_resume_entry got %h want %h", (got.size() > 0) ? got[0] : 65'h0, exp_entry(32'h1C00_0200));
    end
  endtask

  task automatic test_reset_midop();
    do_reset();
    lat = 2;
    ds_allowin = 1'b0;
    for (int t = 0; t < 10; t++) tick();
    ds_allowin = 1'b1;
    tick();
    ds_allowin = 1'b0;
    tick();
    checks++; if (resp_addr.size() != 1 || !fs_to_ds_valid) begin
      errors++; $display("FAIL midop_setup got inflight=%0d valid=%b want 1 1", resp_addr.size(), fs_to_ds_valid);
    end
    reset = 1'b1;
    tick();
    checks++; if (fs_to_ds_valid !== 1'b0 || fs_to_ds_bus !== 65'h0) begin
      errors++; $display("FAIL midop_valid got valid=%b bus=%h want 0 0", fs_to_ds_valid, fs_to_ds_bus);
    end
    reset = 1'b0;
    #1;
    checks++; if (inst_sram_req !== 1'b1 || inst_sram_addr !== RESET_PC) begin
      errors++; $display("FAIL midop_req got req=%b addr=%h want 1 %h", inst_sram_req, inst_sram_addr, RESET_PC);
    end
    ds_allowin = 1'b1;
    got.delete();
    for (int t = 0; t < 6; t++) tick();
    checks++; if (got.size() == 0 || got[0] !== exp_entry(RESET_PC)) begin
      errors++; $display("FAIL midop_entry got %h want %h", (got.size() > 0) ? got[0] : 65'h0, exp_entry(RESET_PC));
    end
  endtask

  initial begin
    reset = 1'b1;
    wb_redirect = 1'b0;
    wb_target = 32'h0;
    br_redirect = 1'b0;
    br_target = 32'h0;
    ds_allowin = 1'b1;
    inst_sram_addr_ok = 1'b1;
    inst_sram_data_ok = 1'b0;
    inst_sram_rdata = 32'h0;
    @(negedge clk);
    test_reset();
    test_sequential();
    test_backpressure();
    test_branch_flush();
    test_dual_redirect();
    test_adef();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
